// File: rtl/wb_commit.sv
// Writeback commit block: 31-entry GPR file (r0 hardwired to zero), HI/LO
// pair and a free-running count of committed writeback cycles. Read ports
// and HI/LO outputs forward the same-cycle writeback data so that readers
// see the value being written without waiting for the edge.
module wb_commit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_wd,
  input  logic        wb_wreg,
  input  logic [31:0] wb_wdata,
  input  logic        wb_whilo,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] commit_cnt
);

  logic [31:0] gpr_q [1:31];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] cnt_q, cnt_d;
  logic        gpr_we;

  // r0 is not stored, so a write aimed at it is simply dropped
  assign gpr_we = wb_wreg && (wb_wd != 5'd0);

  // Next-state for HI/LO and the commit counter; a dual commit counts once
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (wb_whilo) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
    if (wb_wreg || wb_whilo) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Register state update; reset wins over any write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (gpr_we) begin
        gpr_q[wb_wd] <= wb_wdata;
      end
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

  // Read port 1 with same-cycle writeback bypass
  always_comb begin
    rdata1 = '0;
    if (rst || !re1 || raddr1 == 5'd0) begin
      rdata1 = '0;
    end else if (wb_wreg && wb_wd == raddr1) begin
      rdata1 = wb_wdata;
    end else begin
      rdata1 = gpr_q[raddr1];
    end
  end

  // Read port 2 with same-cycle writeback bypass
  always_comb begin
    rdata2 = '0;
    if (rst || !re2 || raddr2 == 5'd0) begin
      rdata2 = '0;
    end else if (wb_wreg && wb_wd == raddr2) begin
      rdata2 = wb_wdata;
    end else begin
      rdata2 = gpr_q[raddr2];
    end
  end

  // HI/LO outputs forward pending writeback data
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst) begin
      hi_o = '0;
      lo_o = '0;
    end else if (wb_whilo) begin
      hi_o = wb_hi;
      lo_o = wb_lo;
    end
  end

  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed scenarios plus a randomized run against an
// array-based reference of the register file, HI/LO and commit count.
module tb_wb_commit;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] commit_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [31:0] m_gpr [0:31];
  logic [31:0] m_hi, m_lo, m_cnt;

  wb_commit dut (
    .clk(clk), .rst(rst),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // apply one clock edge to the reference, using the inputs held over that edge
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_hi = '0; m_lo = '0; m_cnt = '0;
    end else begin
      if (wb_wreg && wb_wd != 0) m_gpr[wb_wd] = wb_wdata;
      if (wb_whilo) begin m_hi = wb_hi; m_lo = wb_lo; end
      if (wb_wreg || wb_whilo) m_cnt = m_cnt + 1;
    end
  endtask

  // one clock: edge, update reference, come back to the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_wreg = 0; wb_wd = 0; wb_wdata = 0;
    wb_whilo = 0; wb_hi = 0; wb_lo = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst || !re || a == 0) return 32'h0;
    if (wb_wreg && wb_wd == a) return wb_wdata;
    return m_gpr[a];
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    wb_wreg = 1; wb_wd = 5; wb_wdata = 32'hCAFE_0005;
    wb_whilo = 1; wb_hi = 32'h1111; wb_lo = 32'h2222;
    re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 5;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL rst_rdata1 got=%h exp=%h", rdata1, 32'h0); end
    n_cmp++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin n_err++; $display("FAIL rst_hilo got=%h/%h exp=0/0", hi_o, lo_o); end
    step();
    step();
    idle_inputs();
    rst = 0;
    re1 = 1; raddr1 = 5;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL reset_read got=%h exp=%h", rdata1, 32'h0); end
    n_cmp++; if (hi_o !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=%h", hi_o, 32'h0); end
    n_cmp++; if (lo_o !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=%h", lo_o, 32'h0); end
    n_cmp++; if (commit_cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt got=%h exp=%h", commit_cnt, 32'h0); end
  endtask

  task automatic test_write_read();
    idle_inputs();
    wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h1234_5678;
    step();
    idle_inputs();
    re1 = 1; raddr1 = 3;
    #1;
    n_cmp++; if (rdata1 !== 32'h1234_5678) begin n_err++; $display("FAIL wr_read got=%h exp=%h", rdata1, 32'h1234_5678); end
    n_cmp++; if (commit_cnt !== 32'd1) begin n_err++; $display("FAIL wr_cnt got=%h exp=%h", commit_cnt, 32'd1); end
    re1 = 0;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL wr_re_off got=%h exp=%h", rdata1, 32'h0); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    wb_wreg = 1; wb_wd = 7; wb_wdata = 32'hDEAD_BEEF;
    re2 = 1; raddr2 = 7; re1 = 1; raddr1 = 7;
    wb_whilo = 1; wb_hi = 32'hA; wb_lo = 32'hB;
    #1;
    n_cmp++; if (rdata2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byp_rdata2 got=%h exp=%h", rdata2, 32'hDEAD_BEEF); end
    n_cmp++; if (rdata1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byp_rdata1 got=%h exp=%h", rdata1, 32'hDEAD_BEEF); end
    n_cmp++; if (hi_o !== 32'hA) begin n_err++; $display("FAIL byp_hi got=%h exp=%h", hi_o, 32'hA); end
    n_cmp++; if (lo_o !== 32'hB) begin n_err++; $display("FAIL byp_lo got=%h exp=%h", lo_o, 32'hB); end
    step();
    idle_inputs();
    re2 = 1; raddr2 = 7;
    #1;
    n_cmp++; if (rdata2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byp_stored got=%h exp=%h", rdata2, 32'hDEAD_BEEF); end
    n_cmp++; if (hi_o !== 32'hA || lo_o !== 32'hB) begin n_err++; $display("FAIL byp_hilo_stored got=%h/%h exp=a/b", hi_o, lo_o); end
    n_cmp++; if (commit_cnt !== 32'd2) begin n_err++; $display("FAIL byp_cnt got=%h exp=%h", commit_cnt, 32'd2); end
  endtask

  task automatic test_reg0();
    idle_inputs();
    wb_wreg = 1; wb_wd = 0; wb_wdata = 32'hFFFF_FFFF;
    re1 = 1; raddr1 = 0;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL r0_same got=%h exp=%h", rdata1, 32'h0); end
    step();
    idle_inputs();
    re1 = 1; raddr1 = 0;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL r0_next got=%h exp=%h", rdata1, 32'h0); end
    n_cmp++; if (commit_cnt !== 32'd3) begin n_err++; $display("FAIL r0_cnt got=%h exp=%h", commit_cnt, 32'd3); end
  endtask

  task automatic test_wrap();
    idle_inputs();
    dut.cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (commit_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload got=%h exp=%h", commit_cnt, 32'hFFFF_FFFF); end
    wb_wreg = 1; wb_wd = 12; wb_wdata = 32'h0BAD_F00D;
    wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2;
    step();
    idle_inputs();
    re1 = 1; raddr1 = 12;
    #1;
    n_cmp++; if (commit_cnt !== 32'h0) begin n_err++; $display("FAIL wrap_cnt got=%h exp=%h", commit_cnt, 32'h0); end
    n_cmp++; if (rdata1 !== 32'h0BAD_F00D) begin n_err++; $display("FAIL wrap_gpr got=%h exp=%h", rdata1, 32'h0BAD_F00D); end
    n_cmp++; if (hi_o !== 32'h1 || lo_o !== 32'h2) begin n_err++; $display("FAIL wrap_hilo got=%h/%h exp=1/2", hi_o, lo_o); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    rst = 1;
    wb_wreg = 1; wb_wd = 9; wb_wdata = 32'h55;
    wb_whilo = 1; wb_hi = 32'h77; wb_lo = 32'h88;
    step();
    rst = 0;
    idle_inputs();
    re1 = 1; raddr1 = 9;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL mid_gpr got=%h exp=%h", rdata1, 32'h0); end
    n_cmp++; if (commit_cnt !== 32'h0) begin n_err++; $display("FAIL mid_cnt got=%h exp=%h", commit_cnt, 32'h0); end
    n_cmp++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin n_err++; $display("FAIL mid_hilo got=%h/%h exp=0/0", hi_o, lo_o); end
    wb_wreg = 1; wb_wd = 9; wb_wdata = 32'h66;
    step();
    idle_inputs();
    re1 = 1; raddr1 = 9;
    #1;
    n_cmp++; if (rdata1 !== 32'h66) begin n_err++; $display("FAIL mid_first_write got=%h exp=%h", rdata1, 32'h66); end
    n_cmp++; if (commit_cnt !== 32'd1) begin n_err++; $display("FAIL mid_first_cnt got=%h exp=%h", commit_cnt, 32'd1); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, eh, el;
    for (int it = 0; it < 400; it++) begin
      rst      = ($urandom_range(0, 39) == 0);
      wb_wreg  = $urandom_range(0, 2) != 0;
      wb_wd    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wb_wdata = $urandom;
      wb_whilo = $urandom_range(0, 2) == 0;
      wb_hi    = $urandom;
      wb_lo    = $urandom;
      re1      = $urandom_range(0, 4) != 0;
      raddr1   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      re2      = $urandom_range(0, 4) != 0;
      raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 7));
      #1;
      e1 = exp_rd(re1, raddr1);
      e2 = exp_rd(re2, raddr2);
      eh = rst ? 32'h0 : (wb_whilo ? wb_hi : m_hi);
      el = rst ? 32'h0 : (wb_whilo ? wb_lo : m_lo);
      n_cmp++; if (rdata1 !== e1) begin n_err++; $display("FAIL rnd_rdata1 it=%0d a=%0d got=%h exp=%h", it, raddr1, rdata1, e1); end
      n_cmp++; if (rdata2 !== e2) begin n_err++; $display("FAIL rnd_rdata2 it=%0d a=%0d got=%h exp=%h", it, raddr2, rdata2, e2); end
      n_cmp++; if (hi_o !== eh) begin n_err++; $display("FAIL rnd_hi it=%0d got=%h exp=%h", it, hi_o, eh); end
      n_cmp++; if (lo_o !== el) begin n_err++; $display("FAIL rnd_lo it=%0d got=%h exp=%h", it, lo_o, el); end
      n_cmp++; if (commit_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt it=%0d got=%h exp=%h", it, commit_cnt, m_cnt); end
      step();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_hi = '0; m_lo = '0; m_cnt = '0;
    rst = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_reg0();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 Parameters: none; all widths fixed (register data 32 bits, register address 5 bits).
REQ-002 Clock clk, reset rst: reset rst, synchronous, active-high; clock clk.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 wb_wd  in  5  writeback destination GPR address.
REQ-006 wb_wreg  in  1  GPR write enable from writeback stage.
REQ-007 wb_wdata  in  32  GPR write data.
REQ-008 wb_whilo  in  1  HI/LO write enable from writeback stage.
REQ-009 wb_hi  in  32  HI write data.
REQ-010 wb_lo  in  32  LO write data.
REQ-011 re1  in  1  read port 1 enable.
REQ-012 raddr1  in  5  read port 1 address.
REQ-013 rdata1  out  32  read port 1 data, combinational.
REQ-014 re2  in  1  read port 2 enable.
REQ-015 raddr2  in  5  read port 2 address.
REQ-016 rdata2  out  32  read port 2 data, combinational.
REQ-017 hi_o  out  32  current HI value, forwarded.
REQ-018 lo_o  out  32  current LO value, forwarded.
REQ-019 commit_cnt  out  32  registered count of committed writeback cycles.

Function
REQ-020 State SHALL be 31 GPRs (addresses 1-31), a 32-bit HI, a 32-bit LO and a 32-bit commit counter; GPR 0 is not stored.
REQ-021 GPR write: at a rising edge with rst=0, wb_wreg=1 and wb_wd!=0, GPR[wb_wd] SHALL take wb_wdata.
REQ-022 A write with wb_wd=0 SHALL be discarded; GPR 0 reads as 0 always.
REQ-023 HI/LO write: at a rising edge with rst=0 and wb_whilo=1, HI SHALL take wb_hi and LO SHALL take wb_lo, both in the same cycle.
REQ-024 GPR and HI/LO writes are independent; both in one cycle SHALL both commit.
REQ-025 Read port n, priority order: rst=1 -> 0; ren=0 -> 0; raddrn=0 -> 0; wb_wreg=1 and wb_wd=raddrn -> wb_wdata (same-cycle bypass); else GPR[raddrn].
REQ-026 Both read ports SHALL be independent; the same address on both ports returns identical data.
REQ-027 hi_o/lo_o: rst=1 -> 0; wb_whilo=1 -> wb_hi/wb_lo (bypass); else stored HI/LO.
REQ-028 Read latency SHALL be zero cycles (combinational from address/enable/write inputs); write latency SHALL be one edge.
REQ-029 commit_cnt SHALL increment by 1 at each rising edge with rst=0 and (wb_wreg=1 or wb_whilo=1), including wb_wd=0 writes.
REQ-030 commit_cnt increments by exactly 1 when wb_wreg and wb_whilo are both 1.
REQ-031 commit_cnt SHALL wrap from 0xFFFFFFFF to 0x00000000 with no flag or stall.
REQ-032 No combinational path SHALL exist from any input to commit_cnt.

Reset
REQ-033 At a rising edge with rst=1: all GPRs, HI, LO and commit_cnt SHALL become 0; any write asserted that cycle SHALL be discarded.
REQ-034 While rst=1: rdata1, rdata2, hi_o and lo_o SHALL be 0 regardless of other inputs.
REQ-035 Reset asserted mid-stream SHALL take effect at the next edge; the first write after rst deasserts commits normally.

Verification
REQ-036 Reset then read: rst=1 for 2 cycles, release, re1=1, raddr1=5 -> rdata1=0, hi_o=0, lo_o=0, commit_cnt=0.
REQ-037 Write/read: write GPR[3]=0x12345678; next cycle raddr1=3, re1=1 -> rdata1=0x12345678, commit_cnt=1; with re1=0 -> rdata1=0.
REQ-038 Bypass: same cycle wb_wreg=1, wb_wd=7, wb_wdata=0xDEADBEEF, raddr2=7, re2=1 -> rdata2=0xDEADBEEF before the edge; wb_whilo=1, wb_hi=0xA, wb_lo=0xB -> hi_o=0xA, lo_o=0xB same cycle.
REQ-039 Register 0: wb_wreg=1, wb_wd=0, wb_wdata=0xFFFFFFFF; raddr1=0, re1=1 same and next cycle -> rdata1=0; commit_cnt increments by 1.
REQ-040 Dual commit and wrap: drive commit_cnt to 0xFFFFFFFF via 2^32-1 commits (or force), then wb_wreg=1 and wb_whilo=1 together -> commit_cnt=0, GPR and HI/LO both updated.
REQ-041 Reset mid-operation: write GPR[9]=0x55 with rst=1 on that edge -> GPR[9] reads 0 after release, commit_cnt=0.
